// File: rtl/etc_report_arbiter.sv
// etc_report_arbiter: latches per-lane speed results and round-robins them into one shared TX FIFO.
// Build option: ARB_FIXED_PRIO_EN selects fixed lowest-index-first priority instead of round-robin.
`default_nettype none

module etc_report_arbiter #(
    parameter int NUM_LANES   = 4,
    parameter int WIDTH_SPEED = 14,
    parameter int WIDTH_ID    = 2
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_LANES-1:0]            lane_done,
    input  logic [NUM_LANES*WIDTH_SPEED-1:0] lane_speed,
    input  logic                            fifo_full,
    output logic                            fifo_wr,
    output logic [WIDTH_ID+WIDTH_SPEED-1:0] fifo_data,
    output logic [NUM_LANES-1:0]            pending,
    output logic [NUM_LANES-1:0]            overflow,
    input  logic                            ovf_clr
);

    logic [WIDTH_SPEED-1:0]          hold_q [NUM_LANES];
    logic [WIDTH_SPEED-1:0]          hold_d [NUM_LANES];
    logic [NUM_LANES-1:0]            pending_q, pending_d;
    logic [NUM_LANES-1:0]            overflow_q, overflow_d;
    logic                            fifo_wr_q, fifo_wr_d;
    logic [WIDTH_ID+WIDTH_SPEED-1:0] fifo_data_q, fifo_data_d;

    logic                            gnt_vld;
    logic [WIDTH_ID-1:0]             gnt_id;
    logic [NUM_LANES-1:0]            gnt_oh;

`ifdef ARB_FIXED_PRIO_EN
    // Scan from the highest index down so the lowest pending lane is the last one kept.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        gnt_oh  = '0;
        for (int off = NUM_LANES - 1; off >= 0; off--) begin
            if (pending_q[off]) begin
                gnt_vld = 1'b1;
                gnt_id  = WIDTH_ID'(off);
                gnt_oh  = NUM_LANES'(1) << off;
            end
        end
        if (fifo_full) begin
            gnt_vld = 1'b0;
            gnt_oh  = '0;
        end
    end
`else
    logic [WIDTH_ID-1:0] rr_q, rr_d;

    // Scan offsets from the far end back to rr so the nearest pending lane wins.
    always_comb begin
        int idx;
        gnt_vld = 1'b0;
        gnt_id  = '0;
        gnt_oh  = '0;
        idx     = 0;
        for (int off = NUM_LANES - 1; off >= 0; off--) begin
            idx = (int'(rr_q) + off) % NUM_LANES;
            if (pending_q[idx]) begin
                gnt_vld = 1'b1;
                gnt_id  = WIDTH_ID'(idx);
                gnt_oh  = NUM_LANES'(1) << idx;
            end
        end
        if (fifo_full) begin
            gnt_vld = 1'b0;
            gnt_oh  = '0;
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (gnt_vld) begin
            rr_d = (gnt_id == WIDTH_ID'(NUM_LANES - 1)) ? '0 : gnt_id + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    always_comb begin
        pending_d   = pending_q;
        overflow_d  = overflow_q;
        fifo_wr_d   = 1'b0;
        fifo_data_d = fifo_data_q;
        for (int i = 0; i < NUM_LANES; i++) begin
            hold_d[i] = hold_q[i];
        end

        if (ovf_clr) begin
            overflow_d = '0;
        end

        if (gnt_vld) begin
            fifo_wr_d   = 1'b1;
            fifo_data_d = {gnt_id, hold_q[gnt_id]};
            pending_d   = pending_q & ~gnt_oh;
        end

        // A capture on the lane being granted re-arms it; only an unsent, ungranted value counts as lost.
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_done[i]) begin
                hold_d[i]    = lane_speed[i*WIDTH_SPEED +: WIDTH_SPEED];
                pending_d[i] = 1'b1;
                if (pending_q[i] && !gnt_oh[i]) begin
                    overflow_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pending_q   <= '0;
            overflow_q  <= '0;
            fifo_wr_q   <= 1'b0;
            fifo_data_q <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            pending_q   <= pending_d;
            overflow_q  <= overflow_d;
            fifo_wr_q   <= fifo_wr_d;
            fifo_data_q <= fifo_data_d;
            for (int i = 0; i < NUM_LANES; i++) begin
                hold_q[i] <= hold_d[i];
            end
        end
    end

    assign fifo_wr   = fifo_wr_q;
    assign fifo_data = fifo_data_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;

endmodule

`default_nettype wire
